lpc_host: RTL and testbench

LPC bus initiator (host end) issuing single-byte I/O read and I/O write cycles to LPC peripherals on a shared LAD[3:0]/LFRAME# bus.
- Accepts one request at a time from a local request/ack port.
- Serializes START, cycle type, address and data nibbles onto LAD, then waits for the peripheral SYNC.
- Returns read data and completion status.
- Sits between the platform/test controller and the LPC bus, opposite the lpc_periph target.

---
 rtl/lpc_host_pkg.sv | 52 +++++
 rtl/lpc_host_sync_mon.sv | 67 ++++++
 rtl/lpc_host.sv | 187 ++++++++++++++++++
 tb/tb_lpc_host.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_host_pkg.sv
// Shared LPC host definitions: FSM state codes, LAD protocol nibbles and the captured request.
// Combinational helpers only; no latency.
// No flow control of its own.
package lpc_host_pkg;

    localparam logic [4:0] ST_IDLE    = 5'd0;
    localparam logic [4:0] ST_START   = 5'd1;
    localparam logic [4:0] ST_CYCTYPE = 5'd2;
    localparam logic [4:0] ST_ADDR1   = 5'd3;
    localparam logic [4:0] ST_ADDR2   = 5'd4;
    localparam logic [4:0] ST_ADDR3   = 5'd5;
    localparam logic [4:0] ST_ADDR4   = 5'd6;
    localparam logic [4:0] ST_WDATA1  = 5'd7;
    localparam logic [4:0] ST_WDATA2  = 5'd8;
    localparam logic [4:0] ST_TAR1    = 5'd9;
    localparam logic [4:0] ST_TAR2    = 5'd10;
    localparam logic [4:0] ST_SYNC    = 5'd11;
    localparam logic [4:0] ST_RDATA1  = 5'd12;
    localparam logic [4:0] ST_RDATA2  = 5'd13;
    localparam logic [4:0] ST_FTAR1   = 5'd14;
    localparam logic [4:0] ST_FTAR2   = 5'd15;
    localparam logic [4:0] ST_ABORT   = 5'd16;

    localparam logic [3:0] LPC_START    = 4'b0000;
    localparam logic [3:0] CYC_IO_READ  = 4'b0000;
    localparam logic [3:0] CYC_IO_WRITE = 4'b0010;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;
    localparam logic [3:0] SYNC_NONE       = 4'b1111;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } host_req_t;

    // Address goes out most-significant nibble first.
    function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = addr[15:12];
            2'd1:    nib = addr[11:8];
            2'd2:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/lpc_host_sync_mon.sv
// Decodes LAD during SYNC into ready/wait/error/abort strobes; optional timeout via LPC_HOST_TIMEOUT_EN.
// Strobes are combinational on the current LAD nibble; counters update each SYNC clock.
// No backpressure; in_sync_i low clears both counters.
import lpc_host_pkg::*;

module lpc_host_sync_mon #(
    parameter int SYNC_TIMEOUT = 16,
    parameter int NORESP_LIMIT = 3
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       in_sync_i,
    input  logic [3:0] lad_i,
    output logic       ready_o,
    output logic       wait_o,
    output logic       error_o,
    output logic       abort_o
);

`ifdef LPC_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic [7:0] noresp_cnt_q, noresp_cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       is_ready, is_error, is_none, is_wait;
    logic       noresp_hit, to_hit;

    always_comb begin
        is_ready = 1'b0;
        is_error = 1'b0;
        is_none  = 1'b0;
        is_wait  = 1'b0;
        case (lad_i)
            SYNC_READY:                      is_ready = 1'b1;
            SYNC_ERROR:                      is_error = 1'b1;
            SYNC_NONE:                       is_none  = 1'b1;
            SYNC_SHORT_WAIT, SYNC_LONG_WAIT: is_wait  = 1'b1;
            default:                         is_wait  = 1'b1;
        endcase
    end

    always_comb begin
        noresp_cnt_d = (in_sync_i && is_none) ? noresp_cnt_q + 8'd1 : 8'd0;
        // Only wait codes advance the timeout; a floating bus is the no-response counter's job.
        to_cnt_d     = !in_sync_i ? 8'd0 : (is_wait ? to_cnt_q + 8'd1 : to_cnt_q);
        noresp_hit   = in_sync_i && is_none && (noresp_cnt_q == 8'(NORESP_LIMIT - 1));
        to_hit       = TO_EN && in_sync_i && is_wait && (to_cnt_q == 8'(SYNC_TIMEOUT - 1));
        abort_o      = noresp_hit || to_hit;
        ready_o      = in_sync_i && is_ready;
        error_o      = in_sync_i && is_error;
        wait_o       = in_sync_i && (is_wait || is_none) && !abort_o;
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            noresp_cnt_q <= 8'd0;
            to_cnt_q     <= 8'd0;
        end else begin
            noresp_cnt_q <= noresp_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

endmodule

// File: rtl/lpc_host.sv
// LPC host issuing single-byte I/O read/write cycles; LPC_HOST_TIMEOUT_EN bounds SYNC wait time.
// Latency request-edge to ack: 14 clocks with no wait states, +1 per SYNC wait clock.
// One request at a time: req_i is ignored while busy_o is high; ack_o pulses once per cycle.
import lpc_host_pkg::*;

module lpc_host #(
    parameter int SYNC_TIMEOUT = 16,
    parameter int NORESP_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        lframe_o,
    inout  logic [3:0]  lad_bus,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        busy_o,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  rdata_o,
    output logic [4:0]  current_state_o
);

    logic [4:0] state_q, state_d;
    host_req_t  req_q, req_d;
    logic       errp_q, errp_d;
    logic [7:0] rbuf_q, rbuf_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_q, ack_d;
    logic       erro_q, erro_d;
    logic [1:0] abort_cnt_q, abort_cnt_d;

    logic       lad_oe;
    logic [3:0] lad_out;
    logic [3:0] lad_in;
    logic       sync_ready, sync_wait, sync_error, sync_abort;

    assign lad_bus = lad_oe ? lad_out : 4'bzzzz;
    assign lad_in  = lad_bus;

    lpc_host_sync_mon #(
        .SYNC_TIMEOUT (SYNC_TIMEOUT),
        .NORESP_LIMIT (NORESP_LIMIT)
    ) u_sync_mon (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .in_sync_i (state_q == ST_SYNC),
        .lad_i     (lad_in),
        .ready_o   (sync_ready),
        .wait_o    (sync_wait),
        .error_o   (sync_error),
        .abort_o   (sync_abort)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        errp_d      = errp_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        erro_d      = 1'b0;
        abort_cnt_d = abort_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    req_d   = '{we: we_i, addr: addr_i, wdata: wdata_i};
                    errp_d  = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START:   state_d = ST_CYCTYPE;
            ST_CYCTYPE: state_d = ST_ADDR1;
            ST_ADDR1:   state_d = ST_ADDR2;
            ST_ADDR2:   state_d = ST_ADDR3;
            ST_ADDR3:   state_d = ST_ADDR4;
            ST_ADDR4:   state_d = req_q.we ? ST_WDATA1 : ST_TAR1;
            ST_WDATA1:  state_d = ST_WDATA2;
            ST_WDATA2:  state_d = ST_TAR1;
            ST_TAR1:    state_d = ST_TAR2;
            ST_TAR2:    state_d = ST_SYNC;
            ST_SYNC: begin
                if (sync_abort) begin
                    abort_cnt_d = 2'd0;
                    state_d     = ST_ABORT;
                end else if (sync_ready || sync_error) begin
                    // An error SYNC still runs the data phase; it only taints the completion.
                    errp_d  = sync_error;
                    state_d = req_q.we ? ST_FTAR1 : ST_RDATA1;
                end else if (sync_wait) begin
                    state_d = ST_SYNC;
                end
            end
            ST_RDATA1: begin
                rbuf_d[3:0] = lad_in;
                state_d     = ST_RDATA2;
            end
            ST_RDATA2: begin
                rbuf_d[7:4] = lad_in;
                state_d     = ST_FTAR1;
            end
            ST_FTAR1:   state_d = ST_FTAR2;
            ST_FTAR2: begin
                ack_d   = 1'b1;
                erro_d  = errp_q;
                if (!req_q.we && !errp_q) begin
                    rdata_d = rbuf_q;
                end
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                if (abort_cnt_q == 2'd3) begin
                    ack_d   = 1'b1;
                    erro_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    abort_cnt_d = abort_cnt_q + 2'd1;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus outputs decode straight from state so an async reset releases LAD immediately.
    always_comb begin
        lframe_o = 1'b1;
        lad_oe   = 1'b0;
        lad_out  = SYNC_NONE;
        case (state_q)
            ST_START: begin
                lframe_o = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = LPC_START;
            end
            ST_CYCTYPE: begin
                lad_oe  = 1'b1;
                lad_out = req_q.we ? CYC_IO_WRITE : CYC_IO_READ;
            end
            ST_ADDR1: begin lad_oe = 1'b1; lad_out = addr_nibble(req_q.addr, 2'd0); end
            ST_ADDR2: begin lad_oe = 1'b1; lad_out = addr_nibble(req_q.addr, 2'd1); end
            ST_ADDR3: begin lad_oe = 1'b1; lad_out = addr_nibble(req_q.addr, 2'd2); end
            ST_ADDR4: begin lad_oe = 1'b1; lad_out = addr_nibble(req_q.addr, 2'd3); end
            ST_WDATA1: begin lad_oe = 1'b1; lad_out = req_q.wdata[3:0]; end
            ST_WDATA2: begin lad_oe = 1'b1; lad_out = req_q.wdata[7:4]; end
            ST_TAR1: begin
                lad_oe  = 1'b1;
                lad_out = SYNC_NONE;
            end
            ST_ABORT: begin
                lframe_o = 1'b0;
                lad_oe   = 1'b1;
                lad_out  = SYNC_NONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            errp_q      <= 1'b0;
            rbuf_q      <= 8'h00;
            rdata_q     <= 8'h00;
            ack_q       <= 1'b0;
            erro_q      <= 1'b0;
            abort_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            errp_q      <= errp_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            erro_q      <= erro_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign busy_o          = (state_q != ST_IDLE);
    assign ack_o           = ack_q;
    assign err_o           = erro_q;
    assign rdata_o         = rdata_q;
    assign current_state_o = state_q;

endmodule

// File: tb/tb_lpc_host.sv
// Self-checking bench for lpc_host: directed cycles plus random cycles against a SYNC-rule model.
module tb_lpc_host;

    localparam int NORESP_LIMIT = 3;
    localparam int SYNC_TIMEOUT = 16;
`ifdef LPC_HOST_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk_i   = 1'b0;
    logic        nrst_i  = 1'b0;
    logic        req_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [15:0] addr_i  = 16'h0;
    logic [7:0]  wdata_i = 8'h0;
    logic        lframe_o, busy_o, ack_o, err_o;
    logic [7:0]  rdata_o;
    logic [4:0]  current_state_o;
    logic        tb_oe   = 1'b1;
    logic [3:0]  tb_lad  = 4'h0;
    wire  [3:0]  lad_bus;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [7:0]  exp_rdata   = 8'h00;
    logic [3:0]  sync_q[$];
    logic [3:0]  host_q[$];

    assign lad_bus = tb_oe ? tb_lad : 4'bzzzz;

    always #5 clk_i = ~clk_i;

    lpc_host #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .NORESP_LIMIT(NORESP_LIMIT)) dut (
        .clk_i           (clk_i),
        .nrst_i          (nrst_i),
        .lframe_o        (lframe_o),
        .lad_bus         (lad_bus),
        .req_i           (req_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .busy_o          (busy_o),
        .ack_o           (ack_o),
        .err_o           (err_o),
        .rdata_o         (rdata_o),
        .current_state_o (current_state_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h, want %h (t=%0t state=%0d)", tag, obs, exp, $time, current_state_o);
        end
    endtask

    // Reference: walk the peripheral's SYNC nibbles and apply the protocol rules directly.
    task automatic model_sync(output int nsync, output bit abort, output bit serr);
        int  nf;
        int  nw;
        bit  done;
        nf = 0; nw = 0; done = 0;
        nsync = 0; abort = 0; serr = 0;
        for (int i = 0; i < sync_q.size() && !done; i++) begin
            nsync++;
            if (sync_q[i] == 4'h0) done = 1;
            else if (sync_q[i] == 4'hA) begin serr = 1; done = 1; end
            else if (sync_q[i] == 4'hF) begin
                nf++;
                if (nf == NORESP_LIMIT) begin abort = 1; done = 1; end
            end else begin
                nf = 0;
                nw++;
                if (TO_EN && nw == SYNC_TIMEOUT) begin abort = 1; done = 1; end
            end
        end
    endtask

    // Caller is at a negedge; returns at the negedge of the ack clock.
    task automatic run_cycle(input bit we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [3:0] rn0, input logic [3:0] rn1, input bit noise);
        int         nsync, hl, total, j;
        bit         abort, serr;
        logic [3:0] v;
        logic       lf;
        model_sync(nsync, abort, serr);
        host_q.delete();
        host_q.push_back(4'h0);
        host_q.push_back(we ? 4'h2 : 4'h0);
        host_q.push_back(addr[15:12]);
        host_q.push_back(addr[11:8]);
        host_q.push_back(addr[7:4]);
        host_q.push_back(addr[3:0]);
        if (we) begin
            host_q.push_back(wdata[3:0]);
            host_q.push_back(wdata[7:4]);
        end
        host_q.push_back(4'hF);
        hl    = host_q.size();
        total = hl + 1 + nsync + (abort ? 4 : (we ? 2 : 4));
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
        @(posedge clk_i);
        for (int k = 1; k <= total + 1; k++) begin
            #1;
            req_i = (noise && k <= total) ? 1'($urandom) : 1'b0;
            if (noise) begin
                we_i = 1'($urandom); addr_i = 16'($urandom); wdata_i = 8'($urandom);
            end
            tb_oe = 1'b1; tb_lad = 4'hF; v = 4'hF; lf = 1'b1;
            if (k <= hl) begin
                tb_oe = 1'b0;
                v     = host_q[k-1];
                lf    = (k != 1);
            end else if (k == hl + 1) begin
                v = 4'hF;
            end else if (k <= hl + 1 + nsync) begin
                tb_lad = sync_q[k-hl-2];
                v      = tb_lad;
            end else if (k <= total) begin
                j = k - hl - 1 - nsync;
                if (abort) begin
                    tb_oe = 1'b0;
                    lf    = 1'b0;
                end else if (!we && j == 1) tb_lad = rn0;
                else if (!we && j == 2) tb_lad = rn1;
                if (!abort) v = tb_lad;
            end
            @(negedge clk_i);
            if (k <= total) begin
                chk("lframe", 16'(lframe_o), 16'(lf));
                chk("lad", 16'(lad_bus), 16'(v));
                chk("busy", 16'(busy_o), 16'd1);
                chk("ack_early", 16'(ack_o), 16'd0);
                @(posedge clk_i);
            end else begin
                if (!we && !abort && !serr) exp_rdata = {rn1, rn0};
                chk("ack", 16'(ack_o), 16'd1);
                chk("busy_ack", 16'(busy_o), 16'd0);
                chk("err", 16'(err_o), 16'(abort || serr));
                chk("rdata", 16'(rdata_o), 16'(exp_rdata));
                chk("lframe_ack", 16'(lframe_o), 16'd1);
            end
        end
    endtask

    task automatic idle(input int n);
        req_i = 1'b0; tb_oe = 1'b1; tb_lad = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            chk("idle_ack", 16'(ack_o), 16'd0);
            chk("idle_busy", 16'(busy_o), 16'd0);
            chk("idle_lframe", 16'(lframe_o), 16'd1);
            chk("idle_lad", 16'(lad_bus), 16'hF);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r_we;
        logic [15:0] r_addr;
        logic [7:0] r_wdata;
        logic [3:0] r_n0, r_n1;
        int         r_nw, r_sel;

        // Reset state; LAD held at 0 by the bench so any host drive would show.
        #2;
        chk("rst_lframe", 16'(lframe_o), 16'd1);
        chk("rst_lad", 16'(lad_bus), 16'h0);
        chk("rst_busy", 16'(busy_o), 16'd0);
        chk("rst_ack", 16'(ack_o), 16'd0);
        chk("rst_err", 16'(err_o), 16'd0);
        chk("rst_rdata", 16'(rdata_o), 16'h00);
        @(negedge clk_i);
        @(negedge clk_i);
        nrst_i = 1'b1;
        idle(2);

        sync_q = '{4'h0};
        run_cycle(1'b1, 16'h0080, 8'hA5, 4'h0, 4'h0, 1'b0);
        idle(1);
        sync_q = '{4'h6, 4'h6, 4'h0};
        run_cycle(1'b0, 16'h002E, 8'h00, 4'h3, 4'hC, 1'b0);
        sync_q = '{4'hF, 4'hF, 4'hF};
        run_cycle(1'b0, 16'h0060, 8'h00, 4'h9, 4'h9, 1'b0);
        idle(1);
        sync_q = '{4'hA};
        run_cycle(1'b1, 16'h03F8, 8'h3C, 4'h0, 4'h0, 1'b0);
        sync_q = '{4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'h0};
        run_cycle(1'b0, 16'h0070, 8'h00, 4'h1, 4'h7, 1'b1);
        sync_q.delete();
        for (int i = 0; i < 100; i++) sync_q.push_back(4'h6);
        sync_q.push_back(4'h0);
        run_cycle(1'b0, 16'h0064, 8'h00, 4'hE, 4'h2, 1'b0);
        idle(1);

        // Reset in ADDR3 of a write to 0x1234: bus released at once, no ack.
        req_i = 1'b1; we_i = 1'b1; addr_i = 16'h1234; wdata_i = 8'h5A;
        @(posedge clk_i);
        #1; req_i = 1'b0; tb_oe = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("addr3_lad", 16'(lad_bus), 16'h3);
        tb_oe = 1'b1; tb_lad = 4'h0; nrst_i = 1'b0;
        #1;
        chk("midrst_lframe", 16'(lframe_o), 16'd1);
        chk("midrst_lad", 16'(lad_bus), 16'h0);
        chk("midrst_busy", 16'(busy_o), 16'd0);
        chk("midrst_ack", 16'(ack_o), 16'd0);
        exp_rdata = 8'h00;
        @(negedge clk_i);
        nrst_i = 1'b1;
        idle(3);
        sync_q = '{4'h5, 4'h0};
        run_cycle(1'b0, 16'h0080, 8'h00, 4'h4, 4'hB, 1'b0);

        for (int t = 0; t < 25; t++) begin
            r_we = 1'($urandom); r_addr = 16'($urandom); r_wdata = 8'($urandom);
            r_n0 = 4'($urandom); r_n1 = 4'($urandom);
            r_nw = $urandom_range(0, 4);
            sync_q.delete();
            for (int i = 0; i < r_nw; i++) begin
                r_sel = $urandom_range(0, 3);
                sync_q.push_back(r_sel == 0 ? 4'h5 : r_sel == 1 ? 4'h6 : r_sel == 2 ? 4'hF : 4'h3);
            end
            r_sel = $urandom_range(0, 5);
            if (r_sel == 0) sync_q.push_back(4'hA);
            else if (r_sel == 1) begin
                sync_q.push_back(4'hF); sync_q.push_back(4'hF); sync_q.push_back(4'hF);
            end else sync_q.push_back(4'h0);
            run_cycle(r_we, r_addr, r_wdata, r_n0, r_n1, (t % 3) == 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
